cbx_pipe_seg: RTL
=================

// Module: cbx_pipe_seg
// PURPOSE
//  Parametrised X-channel connection-block segment: forwards chanx_left_in->chanx_right_out and
//  chanx_right_in->chanx_left_out per track, each track independently bypass (combinational)
//  or registered through PIPE_DEPTH flops. Per-track mode loaded over a configuration-chain
//  shift register (ccff). Sits in the routing fabric between switch blocks; tiles into long wires.
// PARAMETERS
//  CHAN_WIDTH  32  tracks per direction (>=1)
//  PIPE_DEPTH  1   register stages on a registered track (1..CBX_MAX_PIPE_DEPTH=4)
// PORTS
//  clk              in   1             single clock: data pipeline and config chain
//  pReset_n         in   1             asynchronous, active-low reset
//  ccff_head        in   1             config chain serial in
//  ccff_en          in   1             config shift enable, one bit per cycle when high
//  ccff_tail        out  1             config chain serial out = cfg[2*CHAN_WIDTH-1]
//  cfg_valid        out  1             chain fully loaded since reset
//  chanx_left_in    in   CHAN_WIDTH    tracks entering from left
//  chanx_right_in   in   CHAN_WIDTH    tracks entering from right
//  chanx_left_out   out  CHAN_WIDTH    tracks leaving to left (sourced from chanx_right_in)
//  chanx_right_out  out  CHAN_WIDTH    tracks leaving to right (sourced from chanx_left_in)
// BEHAVIOUR
//  - Clock is clk; reset is pReset_n, asynchronous assert, active-low, released synchronously upstream.
//  - Reset: cfg[] = 0, load counter = 0, cfg_valid = 0, all pipeline flops = 0, ccff_tail = 0,
//    both out buses = 0 (gated, see below).
//  - Config chain cfg[0:2W-1], W=CHAN_WIDTH: on clk with ccff_en=1, cfg[0]<=ccff_head,
//    cfg[i+1]<=cfg[i]; ccff_tail = cfg[2W-1] (registered). ccff_en=0: cfg holds.
//  - Mapping: cfg[i] (i<W) is mode of chanx_right_out[i]; cfg[W+i] is mode of chanx_left_out[i].
//    First bit shifted of a 2W-bit load lands in cfg[2W-1]. Mode 0=BYPASS, 1=REGISTERED.
//  - Load counter, width $clog2(2W+1): +1 per shift cycle, saturates at 2W.
//    cfg_valid registered: goes 1 on the clk edge where the counter reaches 2W; stays 1 until reset.
//  - Shifts beyond 2W legal (reconfiguration): counter saturated, cfg_valid stays 1, bits overwrite.
//  - Pipeline: each direction has PIPE_DEPTH x W flops clocked every cycle unconditionally
//    (independent of mode and ccff_en). Stage0 <= *_in; stage k <= stage k-1.
//  - Output per track: gate ? (mode ? stage[PIPE_DEPTH-1][i] : in[i]) : 0,
//    gate = cfg_valid & ~ccff_en. Bypass latency 0 cycles; registered latency PIPE_DEPTH cycles.
//  - Mode change mid-traffic: effective on the cycle after the shift edge; pipeline contents not
//    flushed, so a track switched to REGISTERED presents stale-but-real data for PIPE_DEPTH cycles.
//  - ccff_en high with cfg_valid=1: outputs forced 0 for every cycle ccff_en is high; pipeline
//    keeps advancing, so data resumes immediately when ccff_en drops.
//  - Reset mid-load: counter, cfg and cfg_valid clear immediately; next load restarts from 0.
//  - No X propagation: all flops reset; outputs defined under all input combinations.
// STRUCTURE
//  - cbx_pkg: CBX_MODE_BYPASS=1'b0, CBX_MODE_REG=1'b1, CBX_MAX_PIPE_DEPTH=4, cbx_mode_t typedef.
//  - Sub-module cbx_track_pipe #(W, DEPTH): one direction's flop pipeline + per-track output mux
//    + gate; instantiated twice. Config chain, counter and cfg_valid live in the top.
//  - Elaboration-time check: PIPE_DEPTH in 1..CBX_MAX_PIPE_DEPTH, CHAN_WIDTH>=1.
// TESTING  (W=32, PIPE_DEPTH=2 unless noted)
//  1 Reset: pReset_n=0 mid-clock with inputs 32'hFFFF_FFFF -> all outs 0, cfg_valid=0, ccff_tail=0
//    without waiting for clk edge.
//  2 Shift 64 zeros -> cfg_valid rises on 64th edge; then left_in=32'hA5A5_0F0F -> right_out
//    equals it same cycle (bypass).
//  3 Shift 64 ones -> right_in=32'h1234_5678 for one cycle -> left_out=0x12345678 exactly
//    2 cycles later, 0 before/after (given input returns to 0).
//  4 Load mixed: first 32 bits shifted =1, last 32 =0 -> left_out registered (2-cycle),
//    right_out bypass; verify bit 31 of each bus individually.
//  5 After valid load, raise ccff_en for 3 cycles with live traffic -> outs 0 those cycles,
//    cfg_valid stays 1; 64-cycle-old head pattern appears on ccff_tail.
//  6 Assert pReset_n=0 after 20 shifts, release, shift 64 -> cfg_valid only after full 64
//    (not 44); repeat case 3 at PIPE_DEPTH=1 and 4 for latency 1 and 4.

Source files
------------

// File: rtl/cbx_pkg.sv
// Shared definitions for the X-channel connection-block segment.
// Track modes and the pipeline depth limit.
package cbx_pkg;

    typedef enum logic {
        CBX_MODE_BYPASS = 1'b0,
        CBX_MODE_REG    = 1'b1
    } cbx_mode_t;

    localparam int unsigned CBX_MAX_PIPE_DEPTH = 4;

endpackage

// File: rtl/cbx_pipe_seg_if.sv
// Config-chain and channel bus bundle for cbx_pipe_seg.
// The master drives the chain and the incoming tracks.
interface cbx_pipe_seg_if #(
    parameter int unsigned CHAN_WIDTH = 32
);
    logic                  ccff_head;
    logic                  ccff_en;
    logic                  ccff_tail;
    logic                  cfg_valid;
    logic [CHAN_WIDTH-1:0] chanx_left_in;
    logic [CHAN_WIDTH-1:0] chanx_right_in;
    logic [CHAN_WIDTH-1:0] chanx_left_out;
    logic [CHAN_WIDTH-1:0] chanx_right_out;

    modport master (
        output ccff_head, ccff_en, chanx_left_in, chanx_right_in,
        input  ccff_tail, cfg_valid, chanx_left_out, chanx_right_out
    );

    modport slave (
        input  ccff_head, ccff_en, chanx_left_in, chanx_right_in,
        output ccff_tail, cfg_valid, chanx_left_out, chanx_right_out
    );
endinterface

// File: rtl/cbx_track_pipe.sv
// One direction of the segment: free-running flop pipeline plus per-track
// bypass/registered select, forced to zero when the gate is low.
module cbx_track_pipe
    import cbx_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         gate,
    input  logic [W-1:0] mode,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    // Pipeline advances every cycle regardless of mode or chain activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    always_comb begin
        dout = '0;
        if (gate) begin
            for (int unsigned i = 0; i < W; i++) begin
                dout[i] = (cbx_mode_t'(mode[i]) == CBX_MODE_REG) ? stage_q[DEPTH-1][i] : din[i];
            end
        end
    end

endmodule

// File: rtl/cbx_pipe_seg.sv
// X-channel connection-block segment: per-track bypass or registered forwarding in
// both directions, with track modes loaded through a serial config chain.
module cbx_pipe_seg
    import cbx_pkg::*;
#(
    parameter int unsigned CHAN_WIDTH = 32,
    parameter int unsigned PIPE_DEPTH = 1
) (
    input logic          clk,
    input logic          pReset_n,
    cbx_pipe_seg_if.slave bus
);

    localparam int unsigned CfgLen = 2 * CHAN_WIDTH;
    localparam int unsigned CntW   = $clog2(CfgLen + 1);

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > CBX_MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("cbx_pipe_seg: PIPE_DEPTH out of range");
    end
    if (CHAN_WIDTH < 1) begin : g_bad_width
        $error("cbx_pipe_seg: CHAN_WIDTH must be at least 1");
    end

    logic [CfgLen-1:0] cfg_q, cfg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              gate;

    always_comb begin
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (bus.ccff_en) begin
            cfg_d = {cfg_q[CfgLen-2:0], bus.ccff_head};
            if (cnt_q != CntW'(CfgLen)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Sticky once the chain has been filled; only reset clears it.
        if (cnt_d == CntW'(CfgLen)) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge pReset_n) begin
        if (!pReset_n) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign gate          = valid_q & ~bus.ccff_en;
    assign bus.ccff_tail = cfg_q[CfgLen-1];
    assign bus.cfg_valid = valid_q;

    cbx_track_pipe #(
        .W     (CHAN_WIDTH),
        .DEPTH (PIPE_DEPTH)
    ) u_left_to_right (
        .clk   (clk),
        .rst_n (pReset_n),
        .gate  (gate),
        .mode  (cfg_q[CHAN_WIDTH-1:0]),
        .din   (bus.chanx_left_in),
        .dout  (bus.chanx_right_out)
    );

    cbx_track_pipe #(
        .W     (CHAN_WIDTH),
        .DEPTH (PIPE_DEPTH)
    ) u_right_to_left (
        .clk   (clk),
        .rst_n (pReset_n),
        .gate  (gate),
        .mode  (cfg_q[CfgLen-1:CHAN_WIDTH]),
        .din   (bus.chanx_right_in),
        .dout  (bus.chanx_left_out)
    );

endmodule
